fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 206 ++++++++++++++++++++
 tb/tb_fetch_unit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- program counter sequencer with optional return-address stack.
//
// Ports:
//   Clk       single clock, all state on the rising edge
//   Reset     asynchronous active-low reset
//   Start     hold ProgCtr at START_ADDR, empty the stack, enter IDLE
//   Stall     freeze PC and stack for this cycle
//   Halt      end of program request (RUN -> HALT)
//   BranchEn  branch instruction present
//   ALU_flag  branch condition for relative/absolute modes
//   BrMode    00 relative, 01 absolute, 10 call, 11 return
//   Target    branch offset (signed) or absolute address (unsigned)
//   ProgCtr   registered instruction memory index
//   Done      high while in HALT
//   RasEmpty  return-address stack is empty
//   RasFull   return-address stack is full
//   RasErr    sticky overflow/underflow flag, cleared by Reset or Start
//
// Configuration macro: FETCH_UNIT_RAS_EN
//   defined   : calls push ProgCtr+1 and returns pop it (RAS_DEPTH entries,
//               power of 2, at least 2)
//   undefined : call is a plain absolute jump, return is ProgCtr+1, and the
//               stack flags are tied to empty / not full / no error
module fetch_unit #(
  parameter int          PC_W       = 11,
  parameter int          TGT_W      = 8,
  parameter int          RAS_DEPTH  = 4,
  parameter int unsigned START_ADDR = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             BranchEn,
  input  logic             ALU_flag,
  input  logic [1:0]       BrMode,
  input  logic [TGT_W-1:0] Target,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Done,
  output logic             RasEmpty,
  output logic             RasFull,
  output logic             RasErr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  if (TGT_W > PC_W || RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_param_check
    $error("fetch_unit: need TGT_W <= PC_W and RAS_DEPTH a power of 2, >= 2");
  end

  logic [1:0]      state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [PC_W-1:0] pc_inc, tgt_sext, tgt_zext;

  // All PC arithmetic is PC_W wide, so overflow wraps naturally.
  assign pc_inc   = pc_reg + PC_W'(1);
  assign tgt_sext = PC_W'($signed(Target));
  assign tgt_zext = PC_W'(Target);

`ifdef FETCH_UNIT_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  // Circular buffer: wr_ptr_reg is the next free slot, the top of stack is
  // the slot just below it. A push while full overwrites the oldest entry
  // simply by wrapping the pointer while the count saturates.
  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             err_reg;
  logic             push, pop, err_set, flush;
  logic             ras_empty, ras_full;
  logic [PC_W-1:0]  ras_top;

  assign ras_empty = (count_reg == '0);
  assign ras_full  = (count_reg == CNT_FULL);
  assign ras_top   = ras_mem[wr_ptr_reg - PTR_W'(1)];
  assign flush     = Start || (state_reg == IDLE);
`endif

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
`ifdef FETCH_UNIT_RAS_EN
    push       = 1'b0;
    pop        = 1'b0;
    err_set    = 1'b0;
`endif
    if (Start) begin
      state_next = IDLE;
      pc_next    = START_PC;
    end else begin
      case (state_reg)
        IDLE: begin
          // START_ADDR has been presented throughout IDLE, so the leaving
          // edge advances straight to the following instruction.
          state_next = RUN;
          pc_next    = START_PC + PC_W'(1);
        end
        RUN: begin
          if (Stall) begin
            pc_next = pc_reg;
          end else if (Halt) begin
            state_next = HALT;
          end else if (BranchEn) begin
            case (BrMode)
              2'b00: pc_next = ALU_flag ? (pc_reg + tgt_sext) : pc_inc;
              2'b01: pc_next = ALU_flag ? tgt_zext : pc_inc;
              2'b10: begin
                pc_next = tgt_zext;
`ifdef FETCH_UNIT_RAS_EN
                push    = 1'b1;
                err_set = ras_full;
`endif
              end
              default: begin
`ifdef FETCH_UNIT_RAS_EN
                if (ras_empty) begin
                  pc_next = pc_inc;
                  err_set = 1'b1;
                end else begin
                  pc_next = ras_top;
                  pop     = 1'b1;
                end
`else
                pc_next = pc_inc;
`endif
              end
            endcase
          end else begin
            pc_next = pc_inc;
          end
        end
        default: begin
          // HALT: everything held until Start.
          state_next = state_reg;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg <= IDLE;
      pc_reg    <= START_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  assign ProgCtr = pc_reg;
  assign Done    = (state_reg == HALT);

`ifdef FETCH_UNIT_RAS_EN
  // Entries are only read when count_reg says they are valid, so the
  // storage itself needs no reset.
  always_ff @(posedge Clk) begin
    if (push) begin
      ras_mem[wr_ptr_reg] <= pc_inc;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (!ras_full) begin
          count_reg <= count_reg + CNT_W'(1);
        end
      end else if (pop) begin
        wr_ptr_reg <= wr_ptr_reg - PTR_W'(1);
        count_reg  <= count_reg - CNT_W'(1);
      end

      if (Start) begin
        err_reg <= 1'b0;
      end else if (err_set) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign RasEmpty = ras_empty;
  assign RasFull  = ras_full;
  assign RasErr   = err_reg;
`else
  assign RasEmpty = 1'b1;
  assign RasFull  = 1'b0;
  assign RasErr   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit.
// Directed vector table, hand-written multi-cycle sequences and a random
// run, all compared against a behavioural model built on a queue.
// Honours FETCH_UNIT_RAS_EN the same way the design does.
module tb_fetch_unit;

  localparam int PC_W       = 11;
  localparam int TGT_W      = 8;
  localparam int RAS_DEPTH  = 4;
  localparam int START_ADDR = 0;
  localparam int PC_MASK    = (1 << PC_W) - 1;

  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic             Start = 1'b0;
  logic             Stall = 1'b0;
  logic             Halt = 1'b0;
  logic             BranchEn = 1'b0;
  logic             ALU_flag = 1'b0;
  logic [1:0]       BrMode = 2'b00;
  logic [TGT_W-1:0] Target = '0;
  logic [PC_W-1:0]  ProgCtr;
  logic             Done;
  logic             RasEmpty;
  logic             RasFull;
  logic             RasErr;

  fetch_unit #(
    .PC_W(PC_W), .TGT_W(TGT_W), .RAS_DEPTH(RAS_DEPTH), .START_ADDR(START_ADDR)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Halt(Halt),
    .BranchEn(BranchEn), .ALU_flag(ALU_flag), .BrMode(BrMode), .Target(Target),
    .ProgCtr(ProgCtr), .Done(Done), .RasEmpty(RasEmpty), .RasFull(RasFull),
    .RasErr(RasErr)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural reference model ----------------
  typedef enum {PH_IDLE, PH_RUN, PH_HALT} phase_t;
  phase_t m_phase;
  int     m_pc;
  int     m_ras[$];
  bit     m_err;

  task automatic m_reset();
    m_phase = PH_IDLE;
    m_pc    = START_ADDR;
    m_ras.delete();
    m_err   = 1'b0;
  endtask

  // Applies one rising edge worth of behaviour using the current inputs.
  task automatic model_edge();
    int off;
    int nxt;
    nxt = (m_pc + 1) & PC_MASK;
    off = int'(Target);
    if (Target[TGT_W-1]) off = off - (1 << TGT_W);
    if (Start) begin
      m_reset();
    end else if (m_phase == PH_IDLE) begin
      m_phase = PH_RUN;
      m_pc    = (START_ADDR + 1) & PC_MASK;
    end else if (m_phase == PH_HALT || Stall) begin
      // nothing moves
    end else if (Halt) begin
      m_phase = PH_HALT;
    end else if (!BranchEn) begin
      m_pc = nxt;
    end else begin
      case (BrMode)
        2'd0: m_pc = ALU_flag ? ((m_pc + off) & PC_MASK) : nxt;
        2'd1: m_pc = ALU_flag ? int'(Target) : nxt;
        2'd2: begin
`ifdef FETCH_UNIT_RAS_EN
          m_ras.push_back(nxt);
          if (m_ras.size() > RAS_DEPTH) begin
            void'(m_ras.pop_front());
            m_err = 1'b1;
          end
`endif
          m_pc = int'(Target);
        end
        default: begin
`ifdef FETCH_UNIT_RAS_EN
          if (m_ras.size() == 0) begin
            m_pc  = nxt;
            m_err = 1'b1;
          end else begin
            m_pc = m_ras.pop_back();
          end
`else
          m_pc = nxt;
`endif
        end
      endcase
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model(input string name);
    check({name, " pc"},   32'(ProgCtr), m_pc);
    check({name, " done"}, 32'(Done), (m_phase == PH_HALT) ? 1 : 0);
`ifdef FETCH_UNIT_RAS_EN
    check({name, " empty"}, 32'(RasEmpty), (m_ras.size() == 0) ? 1 : 0);
    check({name, " full"},  32'(RasFull), (m_ras.size() == RAS_DEPTH) ? 1 : 0);
    check({name, " err"},   32'(RasErr), 32'(m_err));
`else
    check({name, " empty"}, 32'(RasEmpty), 1);
    check({name, " full"},  32'(RasFull), 0);
    check({name, " err"},   32'(RasErr), 0);
`endif
  endtask

  task automatic set_in(input bit st, input bit sl, input bit hl, input bit en,
                        input bit fl, input int md, input int tg);
    Start    = st;
    Stall    = sl;
    Halt     = hl;
    BranchEn = en;
    ALU_flag = fl;
    BrMode   = 2'(md);
    Target   = TGT_W'(tg);
  endtask

  // One clock: model steps on the same inputs, DUT sampled 1 time unit later.
  task automatic tick(input string name);
    model_edge();
    @(posedge Clk);
    #1;
    compare_model(name);
  endtask

  // Restart and steer the PC to p with a single branch.
  task automatic goto_pc(input int p);
    int d;
    set_in(1, 0, 0, 0, 0, 0, 0);
    tick("goto start");
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick("goto idle");
    d = (p - m_pc) & PC_MASK;
    if (d < 128 || d >= (1 << PC_W) - 128) begin
      set_in(0, 0, 0, 1, 1, 0, d & 8'hFF);
    end else begin
      set_in(0, 0, 0, 1, 1, 1, p);
    end
    tick("goto jump");
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int pc;
    bit en;
    bit flag;
    int mode;
    int tgt;
    int exp_pc;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs[NVEC];

  initial begin
    int ret_exp[4];
    int call_tgt[5];

    vecs[0]  = '{pc: 10,   en: 1, flag: 1, mode: 0, tgt: 'hFC, exp_pc: 6};
    vecs[1]  = '{pc: 10,   en: 1, flag: 0, mode: 0, tgt: 'hFC, exp_pc: 11};
    vecs[2]  = '{pc: 2047, en: 0, flag: 0, mode: 0, tgt: 0,    exp_pc: 0};
    vecs[3]  = '{pc: 2040, en: 1, flag: 1, mode: 0, tgt: 'h10, exp_pc: 8};
    vecs[4]  = '{pc: 10,   en: 1, flag: 1, mode: 1, tgt: 200,  exp_pc: 200};
    vecs[5]  = '{pc: 10,   en: 1, flag: 0, mode: 1, tgt: 200,  exp_pc: 11};
    vecs[6]  = '{pc: 100,  en: 1, flag: 1, mode: 0, tgt: 'h7F, exp_pc: 227};
    vecs[7]  = '{pc: 5,    en: 1, flag: 1, mode: 0, tgt: 'h80, exp_pc: 1925};
    vecs[8]  = '{pc: 200,  en: 0, flag: 1, mode: 1, tgt: 3,    exp_pc: 201};
    vecs[9]  = '{pc: 10,   en: 1, flag: 0, mode: 2, tgt: 50,   exp_pc: 50};
    vecs[10] = '{pc: 10,   en: 1, flag: 0, mode: 3, tgt: 50,   exp_pc: 11};

    // ---- reset state ----
    m_reset();
    #1;
    compare_model("reset async");
    repeat (2) @(posedge Clk);
    #1;
    compare_model("reset held");
    Reset = 1'b1;

    // ---- table ----
    for (int i = 0; i < NVEC; i++) begin
      goto_pc(vecs[i].pc);
      set_in(0, 0, 0, vecs[i].en, vecs[i].flag, vecs[i].mode, vecs[i].tgt);
      tick($sformatf("vec%0d", i));
      check($sformatf("vec%0d table pc", i), 32'(ProgCtr), vecs[i].exp_pc);
      $display("vec %0d: pc %0d en %0d flag %0d mode %0d tgt %0d -> pc %0d",
               i, vecs[i].pc, vecs[i].en, vecs[i].flag, vecs[i].mode,
               vecs[i].tgt, ProgCtr);
      set_in(0, 0, 0, 0, 0, 0, 0);
    end

    // ---- asynchronous reset at PC 37, then count up ----
    goto_pc(37);
    #3;
    Reset = 1'b0;
    #1;
    m_reset();
    check("async rst pc", 32'(ProgCtr), 0);
    check("async rst done", 32'(Done), 0);
    @(posedge Clk);
    #1;
    check("rst held pc", 32'(ProgCtr), 0);
    Reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick("count");
      check($sformatf("count step %0d", i), 32'(ProgCtr), i);
    end
    $display("seq reset: pc forced to 0, counted to %0d", ProgCtr);

    // ---- call / return / underflow ----
    goto_pc(5);
    set_in(0, 0, 0, 1, 0, 2, 100);
    tick("call");
    check("call pc", 32'(ProgCtr), 100);
    set_in(0, 0, 0, 1, 0, 3, 0);
    tick("ret1");
`ifdef FETCH_UNIT_RAS_EN
    check("ret1 pc", 32'(ProgCtr), 6);
`else
    check("ret1 pc", 32'(ProgCtr), 101);
`endif
    tick("ret2");
`ifdef FETCH_UNIT_RAS_EN
    check("ret2 pc", 32'(ProgCtr), 7);
    check("ret2 err", 32'(RasErr), 1);
`else
    check("ret2 pc", 32'(ProgCtr), 102);
    check("ret2 err", 32'(RasErr), 0);
`endif
    $display("seq call/return: final pc %0d err %0d", ProgCtr, RasErr);

    // ---- nested calls beyond depth ----
    goto_pc(5);
    call_tgt = '{20, 40, 60, 80, 100};
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, 1, 0, 2, call_tgt[i]);
      tick("nest call");
      check($sformatf("nest call%0d pc", i), 32'(ProgCtr), call_tgt[i]);
`ifdef FETCH_UNIT_RAS_EN
      check($sformatf("nest call%0d full", i), 32'(RasFull), (i >= 3) ? 1 : 0);
      check($sformatf("nest call%0d err", i), 32'(RasErr), (i == 4) ? 1 : 0);
`endif
    end
`ifdef FETCH_UNIT_RAS_EN
    ret_exp = '{81, 61, 41, 21};
`else
    ret_exp = '{101, 102, 103, 104};
`endif
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 1, 0, 3, 0);
      tick("nest ret");
      check($sformatf("nest ret%0d pc", i), 32'(ProgCtr), ret_exp[i]);
    end
    check("nest end empty", 32'(RasEmpty), 1);
    $display("seq nested: final pc %0d empty %0d", ProgCtr, RasEmpty);

    // ---- stall beats halt and call, then halt holds until Start ----
    goto_pc(30);
    set_in(0, 0, 0, 1, 0, 2, 50);
    tick("pre call");
    set_in(0, 1, 1, 1, 0, 2, 90);
    tick("stall");
    check("stall pc", 32'(ProgCtr), 50);
    check("stall done", 32'(Done), 0);
`ifdef FETCH_UNIT_RAS_EN
    check("stall empty", 32'(RasEmpty), 0);
`else
    check("stall empty", 32'(RasEmpty), 1);
`endif
    set_in(0, 0, 1, 1, 0, 2, 90);
    tick("halt");
    check("halt done", 32'(Done), 1);
    check("halt pc", 32'(ProgCtr), 50);
    for (int i = 0; i < 5; i++) begin
      set_in(0, $urandom_range(0, 1) == 1, 0, 1, 1, $urandom_range(0, 3), $urandom_range(0, 255));
      tick("halted");
      check($sformatf("halted%0d pc", i), 32'(ProgCtr), 50);
    end
    set_in(1, 0, 0, 0, 0, 0, 0);
    tick("restart");
    check("restart pc", 32'(ProgCtr), 0);
    check("restart done", 32'(Done), 0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick("restart run");
    check("restart run pc", 32'(ProgCtr), 1);
    $display("seq stall/halt: restarted at pc %0d", ProgCtr);

    // ---- randomized run against the model ----
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 3),
             $urandom_range(0, 255));
      tick($sformatf("rand%0d", i));
    end
    $display("random: 3000 cycles done, pc %0d", ProgCtr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
